// File: rtl/clk_pkg.sv
// ============================================================================
// clk_pkg : shared types and defaults for the clock-enable / reset sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_pkg;

  typedef enum logic {
    SEQ  = 1'b0,
    DONE = 1'b1
  } clk_seq_e;

  localparam int CLK_CHANNELS  = 4;
  localparam int CLK_DIV_WIDTH = 16;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int clk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// clk_div_chan : one divider channel (enable strobe + 50% phase, shadowed div)
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_chan
  import clk_pkg::*;
#(
  parameter int DIV_WIDTH = CLK_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_cfg_i,
  input  logic                 cfg_load_i,
  output logic                 en_o,
  output logic                 ph_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 ph_q, ph_d;

  assign en_o = (cnt_q == div_q);
  assign ph_o = ph_q;

  always_comb begin
    cnt_d     = cnt_q + DIV_WIDTH'(1);
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ph_d      = ph_q;
    if (en_o) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
      // The new divisor only takes effect at a period boundary.
      if (pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
    end
    if (cfg_load_i) begin
      shadow_d  = div_cfg_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= div_cfg_i;
      shadow_q  <= div_cfg_i;
      pending_q <= 1'b0;
      ph_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ph_q      <= ph_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_rst_gen.sv
// ============================================================================
// clk_rst_gen : per-domain enable strobes plus ordered, restartable reset release
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_rst_gen
  import clk_pkg::*;
#(
  parameter int CHANNELS  = CLK_CHANNELS,
  parameter int DIV_WIDTH = CLK_DIV_WIDTH,
  parameter int RST_HOLD  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS-1:0][DIV_WIDTH-1:0] div_cfg,
  input  logic                               cfg_load,
  input  logic                               seq_restart,
  output logic [CHANNELS-1:0]                en_o,
  output logic [CHANNELS-1:0]                ph_o,
  output logic [CHANNELS-1:0]                rst_o,
  output logic                               ready
);

  localparam int IDX_W  = clk_idx_w(CHANNELS);
  localparam int HOLD_W = clk_idx_w(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .div_cfg_i  (div_cfg[g]),
      .cfg_load_i (cfg_load),
      .en_o       (en_o[g]),
      .ph_o       (ph_o[g])
    );
  end

  clk_seq_e            state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CHANNELS-1:0] rst_q, rst_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    if (seq_restart) begin
      state_d = SEQ;
      idx_d   = '0;
      hold_d  = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        SEQ: begin
          // Release only on the domain's own strobe so its reset edge is aligned.
          if (hold_q == HOLD_MAX && en_o[idx_q]) begin
            rst_d[idx_q] = 1'b0;
            hold_d       = '0;
            idx_d        = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              ready_d = 1'b1;
            end
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ;
      idx_q   <= '0;
      hold_q  <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_o = rst_q;
  assign ready = ready_q;

endmodule

`default_nettype wire
